// File: rtl/elevator_car.sv
// Single-car elevator model: car position FSM plus door FSM driven by controller commands.
// Optional macro ELEVATOR_CAR_INTERLOCK_EN flags engine commands issued while the door is not closed.
module elevator_car #(
    parameter int BUTTONS_WIDTH = 8,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               engine,
    input  logic [1:0]               door,
    output logic [2:0]               level_display,
    output logic [BUTTONS_WIDTH-1:0] floor_sensor,
    output logic                     door_closed,
    output logic                     door_opened,
    output logic                     moving,
    output logic                     fault
);

    localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TCW-1:0] TRAVEL_LOAD = TCW'(TRAVEL_CYCLES - 1);
    localparam logic [DCW-1:0] DOOR_LOAD   = DCW'(DOOR_CYCLES - 1);
    localparam logic [2:0]     TOP_FLOOR   = 3'(BUTTONS_WIDTH - 1);

`ifdef ELEVATOR_CAR_INTERLOCK_EN
    localparam bit INTERLOCK = 1'b1;
`else
    localparam bit INTERLOCK = 1'b0;
`endif

    typedef enum logic [1:0] {
        ALIGNED,
        MOVING_UP,
        MOVING_DOWN
    } car_state_t;

    typedef enum logic [1:0] {
        CLOSED,
        OPENING,
        OPEN,
        CLOSING
    } door_state_t;

    car_state_t  car_state, car_next;
    door_state_t door_state, door_next;
    logic [TCW-1:0] travel_cnt, travel_next;
    logic [DCW-1:0] door_cnt, door_cnt_next;
    logic [2:0]     level, level_next;
    logic           fault_r, fault_set;

    logic eng_up, eng_down, eng_bad;
    logic door_open_cmd, door_close_cmd, door_bad;
    logic door_priority;

    assign eng_up         = (engine == 2'b01);
    assign eng_down       = (engine == 2'b10);
    assign eng_bad        = (engine == 2'b11);
    assign door_open_cmd  = (door == 2'b01);
    assign door_close_cmd = (door == 2'b10);
    assign door_bad       = (door == 2'b11);

    // An open request on a parked, closed car wins over any engine request that cycle.
    assign door_priority = (car_state == ALIGNED) && (door_state == CLOSED) && door_open_cmd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            car_state  <= ALIGNED;
            door_state <= CLOSED;
            travel_cnt <= '0;
            door_cnt   <= '0;
            level      <= '0;
            fault_r    <= 1'b0;
        end else begin
            car_state  <= car_next;
            door_state <= door_next;
            travel_cnt <= travel_next;
            door_cnt   <= door_cnt_next;
            level      <= level_next;
            fault_r    <= fault_r | fault_set;
        end
    end

    always_comb begin
        car_next    = car_state;
        travel_next = travel_cnt;
        level_next  = level;
        fault_set   = eng_bad | door_bad;

        case (car_state)
            ALIGNED: begin
                if (!door_priority && (eng_up || eng_down)) begin
                    if (door_state != CLOSED) begin
                        if (INTERLOCK) fault_set = 1'b1;
                    end else if (eng_up) begin
                        if (level == TOP_FLOOR) begin
                            fault_set = 1'b1;
                        end else begin
                            car_next    = MOVING_UP;
                            travel_next = TRAVEL_LOAD;
                        end
                    end else begin
                        if (level == 3'd0) begin
                            fault_set = 1'b1;
                        end else begin
                            car_next    = MOVING_DOWN;
                            travel_next = TRAVEL_LOAD;
                        end
                    end
                end
            end
            MOVING_UP, MOVING_DOWN: begin
                if (door_open_cmd) fault_set = 1'b1;
                if (travel_cnt == '0) begin
                    car_next   = ALIGNED;
                    level_next = (car_state == MOVING_UP) ? level + 3'd1 : level - 3'd1;
                end else begin
                    travel_next = travel_cnt - TCW'(1);
                end
            end
            default: car_next = ALIGNED;
        endcase
    end

    always_comb begin
        door_next     = door_state;
        door_cnt_next = door_cnt;

        case (door_state)
            CLOSED: begin
                if (door_open_cmd && (car_state == ALIGNED)) begin
                    door_next     = OPENING;
                    door_cnt_next = DOOR_LOAD;
                end
            end
            OPENING: begin
                if (door_close_cmd) begin
                    door_next     = CLOSING;
                    door_cnt_next = DOOR_LOAD;
                end else if (door_cnt == '0) begin
                    door_next = OPEN;
                end else begin
                    door_cnt_next = door_cnt - DCW'(1);
                end
            end
            OPEN: begin
                if (door_close_cmd) begin
                    door_next     = CLOSING;
                    door_cnt_next = DOOR_LOAD;
                end
            end
            CLOSING: begin
                if (door_open_cmd) begin
                    door_next     = OPENING;
                    door_cnt_next = DOOR_LOAD;
                end else if (door_cnt == '0) begin
                    door_next = CLOSED;
                end else begin
                    door_cnt_next = door_cnt - DCW'(1);
                end
            end
            default: door_next = CLOSED;
        endcase
    end

    assign level_display = level;
    assign floor_sensor  = (car_state == ALIGNED) ? (BUTTONS_WIDTH'(1) << level) : '0;
    assign moving        = (car_state != ALIGNED);
    assign door_closed   = (door_state == CLOSED);
    assign door_opened   = (door_state == OPEN);
    assign fault         = fault_r;

endmodule

// File: tb/tb_elevator_car.sv
// Directed self-checking bench for elevator_car with default parameters.
module tb_elevator_car;

`ifdef ELEVATOR_CAR_INTERLOCK_EN
    localparam logic [31:0] EXP_IL_FAULT = 32'd1;
`else
    localparam logic [31:0] EXP_IL_FAULT = 32'd0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] engine = 2'b00;
    logic [1:0] door = 2'b00;
    logic [2:0] level_display;
    logic [7:0] floor_sensor;
    logic       door_closed, door_opened, moving, fault;

    int errors = 0;
    int checks = 0;

    elevator_car #(
        .BUTTONS_WIDTH(8),
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .engine       (engine),
        .door         (door),
        .level_display(level_display),
        .floor_sensor (floor_sensor),
        .door_closed  (door_closed),
        .door_opened  (door_opened),
        .moving       (moving),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_level", level_display, 0);
        chk("rst_fs", floor_sensor, 8'h01);
        chk("rst_closed", door_closed, 1);
        chk("rst_opened", door_opened, 0);
        chk("rst_moving", moving, 0);
        chk("rst_fault", fault, 0);
        tick();
        reset = 1'b1;

        // Climb floor 0 to 7 with engine held up
        engine = 2'b01;
        for (int f = 0; f < 7; f++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                chk("climb_moving", moving, 1);
                chk("climb_level", level_display, f);
                chk("climb_fs", floor_sensor, 0);
            end
            tick();
            chk("arrive_moving", moving, 0);
            chk("arrive_level", level_display, f + 1);
            chk("arrive_fs", floor_sensor, 32'(1) << (f + 1));
        end
        engine = 2'b00;
        chk("climb_fault", fault, 0);
        chk("top_fs", floor_sensor, 8'h80);

        // Door cycle at top floor
        door = 2'b01;
        tick();
        chk("open1_closed", door_closed, 0);
        chk("open1_opened", door_opened, 0);
        door = 2'b00;
        tick();
        chk("open2_opened", door_opened, 0);
        tick();
        chk("open3_opened", door_opened, 1);
        chk("open3_closed", door_closed, 0);
        door = 2'b10;
        tick();
        chk("close1_opened", door_opened, 0);
        chk("close1_closed", door_closed, 0);
        door = 2'b00;
        tick();
        chk("close2_closed", door_closed, 0);
        tick();
        chk("close3_closed", door_closed, 1);
        chk("door_fault", fault, 0);

        // Up at top floor
        engine = 2'b01;
        tick();
        chk("top_up_moving", moving, 0);
        chk("top_up_level", level_display, 7);
        chk("top_up_fault", fault, 1);
        engine = 2'b00;

        // Reset, climb to 3, reverse request during travel 3->4
        reset = 1'b0;
        #2;
        chk("rst2_fault", fault, 0);
        chk("rst2_level", level_display, 0);
        tick();
        reset = 1'b1;
        engine = 2'b01;
        repeat (15) tick();
        chk("l3_level", level_display, 3);
        chk("l3_moving", moving, 0);
        tick();
        tick();
        engine = 2'b10;
        tick();
        tick();
        chk("rev_moving", moving, 1);
        chk("rev_level", level_display, 3);
        tick();
        chk("rev_arrive_level", level_display, 4);
        chk("rev_arrive_moving", moving, 0);
        chk("rev_arrive_fs", floor_sensor, 8'h10);
        chk("rev_fault", fault, 0);
        engine = 2'b00;

        // Close during OPENING
        door = 2'b01;
        tick();
        chk("abort_opening", door_closed, 0);
        door = 2'b10;
        tick();
        chk("abort_closing_closed", door_closed, 0);
        chk("abort_closing_opened", door_opened, 0);
        door = 2'b00;
        tick();
        chk("abort_mid", door_closed, 0);
        tick();
        chk("abort_done", door_closed, 1);

        // Engine up while door open
        door = 2'b01;
        tick();
        door = 2'b00;
        tick();
        tick();
        chk("il_opened", door_opened, 1);
        engine = 2'b01;
        tick();
        chk("il_moving", moving, 0);
        chk("il_level", level_display, 4);
        chk("il_fault", fault, EXP_IL_FAULT);
        engine = 2'b00;
        door = 2'b10;
        tick();
        door = 2'b00;
        tick();
        tick();
        chk("il_reclosed", door_closed, 1);

        // One floor down
        engine = 2'b10;
        repeat (4) tick();
        chk("down_moving", moving, 1);
        chk("down_level", level_display, 4);
        tick();
        chk("down_level_arr", level_display, 3);
        chk("down_fs", floor_sensor, 8'h08);
        chk("down_moving_arr", moving, 0);
        engine = 2'b00;

        // Illegal door command
        door = 2'b11;
        tick();
        chk("bad_door_fault", fault, 1);
        chk("bad_door_closed", door_closed, 1);
        chk("bad_door_opened", door_opened, 0);
        door = 2'b00;

        // Open while moving, then reset mid-travel 2->3
        reset = 1'b0;
        #2;
        tick();
        reset = 1'b1;
        engine = 2'b01;
        repeat (12) tick();
        chk("mid_level", level_display, 2);
        chk("mid_moving", moving, 1);
        chk("mid_fs", floor_sensor, 0);
        door = 2'b01;
        tick();
        chk("mv_open_fault", fault, 1);
        chk("mv_open_closed", door_closed, 1);
        chk("mv_open_moving", moving, 1);
        door = 2'b00;
        #2;
        reset = 1'b0;
        #1;
        chk("async_level", level_display, 0);
        chk("async_fs", floor_sensor, 8'h01);
        chk("async_moving", moving, 0);
        chk("async_closed", door_closed, 1);
        chk("async_opened", door_opened, 0);
        chk("async_fault", fault, 0);
        engine = 2'b00;
        tick();
        reset = 1'b1;
        tick();

        // Down at floor 0
        engine = 2'b10;
        tick();
        chk("bot_down_moving", moving, 0);
        chk("bot_down_level", level_display, 0);
        chk("bot_down_fault", fault, 1);
        engine = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
